fifo_share_ctrl: RTL

- Sequences one shared fifo instance (WIDTH/DEPTH as in the fifo block) between NREQ producers and one registered consumer port.
- Push side: round-robin arbiter with optional packet lock (burst hold) that never pushes into a full FIFO.
- Pop side: pop scheduler feeding a 1-deep valid/ready output register.
- Also owns the FIFO's synchronous reset for flushing. Sits directly between producer blocks and the fifo instance.

---
 rtl/fifo_share_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_share_ctrl.sv
// Shares one FIFO between NREQ producers: round-robin push arbiter with burst
// lock, pop scheduler into a 1-deep valid/ready output register, flush control.
module fifo_share_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  fifo_push,
  output logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [WIDTH-1:0]      fifo_dout,
  output logic                  fifo_rst,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  locked
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(MAXBURST - 1);

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return PW'(s);
  endfunction

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             locked_q, locked_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]    win_idx;
  logic             found;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    if (!rst && !flush && !fifo_full) begin
      if (locked_q) begin
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          win_idx      = owner_q;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req[rr_idx(ptr_q, k)]) begin
            found                 = 1'b1;
            gnt[rr_idx(ptr_q, k)] = 1'b1;
            win_idx               = rr_idx(ptr_q, k);
          end
        end
      end
    end
  end

  assign fifo_push = |gnt;
  assign fifo_data = fifo_push ? data_in[int'(win_idx)*WIDTH +: WIDTH] : '0;
  assign fifo_rst  = flush;
  // Pop is held off during reset too: the output register is cleared then and could not capture the word.
  assign fifo_pop  = !rst && !flush && !fifo_empty && (!out_valid_q || out_ready);

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      locked_d    = 1'b0;
      bcnt_d      = '0;
    end else begin
      if (fifo_push) begin
        // A packet ends on its last beat or when the burst cap is reached.
        if (last[win_idx] || bcnt_q == BCNT_LAST) begin
          locked_d = 1'b0;
          bcnt_d   = '0;
          ptr_d    = win_idx;
        end else begin
          locked_d = 1'b1;
          owner_d  = win_idx;
          bcnt_d   = bcnt_q + BW'(1);
        end
      end
      if (fifo_pop) begin
        out_data_d  = fifo_dout;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= PW'(NREQ - 1);
      owner_q     <= '0;
      locked_q    <= 1'b0;
      bcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      locked_q    <= locked_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign locked    = locked_q;

endmodule
